perf_counter_bank: RTL and testbench

Parametrised bank of NUM_CNT performance counters sharing one chip-level start/clear control FSM.
- Each lane adds a multi-bit increment per cycle.
- Modes: wrap with sticky overflow, or saturate at all-ones.
- Snapshot: atomically copies all live counters into shadow registers.
- Registered read port selects one lane, live or shadow.
- Sits in tile/cohort perf logic; replaces per-event single-bit counter instances.

---
 rtl/perf_pkg.sv | 13 +
 rtl/perf_counter_lane.sv | 57 +++++
 rtl/perf_counter_bank.sv | 99 +++++++++
 tb/tb_perf_counter_bank.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and defaults for the performance-counter bank.
package perf_pkg;

  localparam int PERF_BANK_DEF_WIDTH = 64;
  localparam int PERF_BANK_DEF_INC_W = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNTING = 2'd1,
    S_CLEAR    = 2'd2
  } perf_bank_state_t;

endpackage

// File: rtl/perf_counter_lane.sv
// One counter lane: live counter, shadow copy and sticky overflow flag.
module perf_counter_lane
  import perf_pkg::*;
#(
  parameter int WIDTH    = PERF_BANK_DEF_WIDTH,
  parameter int INC_W    = PERF_BANK_DEF_INC_W,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic [INC_W-1:0] amount,
  input  logic             clear,
  input  logic             snap,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] shadow,
  output logic             ovf
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_shadow;
  logic             r_ovf;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;

  // Carry-out either wraps to the low bits or clamps to all-ones.
  function automatic logic [WIDTH-1:0] f_wrap_or_sat(input logic [WIDTH:0] sum);
    if (sum[WIDTH] && (SATURATE != 0)) return '1;
    return sum[WIDTH-1:0];
  endfunction

  assign w_sum   = {1'b0, r_cnt} + (WIDTH+1)'(amount);
  assign w_carry = w_sum[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else begin
      // Shadow takes the pre-edge value, so same-edge increments/clears are excluded.
      if (snap) r_shadow <= r_cnt;
      if (clear) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (inc_en) begin
        r_cnt <= f_wrap_or_sat(w_sum);
        if (w_carry) r_ovf <= 1'b1;
      end
    end
  end

  assign cnt    = r_cnt;
  assign shadow = r_shadow;
  assign ovf    = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of counter lanes under one start/clear FSM, with a registered
// live/shadow read port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT  = 8,
  parameter int WIDTH    = PERF_BANK_DEF_WIDTH,
  parameter int INC_W    = PERF_BANK_DEF_INC_W,
  parameter int SATURATE = 0,
  parameter int IDX_W    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     toggle_trigger,
  input  logic                     clear_trigger,
  input  logic                     snapshot_trigger,
  input  logic [NUM_CNT-1:0]       inc_valid,
  input  logic [NUM_CNT*INC_W-1:0] inc_amount,
  input  logic                     rd_en,
  input  logic [IDX_W-1:0]         rd_idx,
  input  logic                     rd_shadow,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [NUM_CNT-1:0]       ovf_sticky,
  output logic                     counting
);

  perf_bank_state_t r_state;
  perf_bank_state_t w_state_nxt;
  logic             w_in_count;
  logic             w_in_clear;
  logic [WIDTH-1:0] w_live [NUM_CNT];
  logic [WIDTH-1:0] w_shad [NUM_CNT];
  logic [WIDTH-1:0] w_rd_sel;
  logic             r_rd_valid;
  logic [WIDTH-1:0] r_rd_data;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (clear_trigger)       w_state_nxt = S_CLEAR;
        else if (toggle_trigger) w_state_nxt = S_COUNTING;
      end
      S_COUNTING: if (clear_trigger) w_state_nxt = S_CLEAR;
      S_CLEAR:    w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_in_count = (r_state == S_COUNTING);
  assign w_in_clear = (r_state == S_CLEAR);
  assign counting   = w_in_count;

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_lane
    perf_counter_lane #(
      .WIDTH    (WIDTH),
      .INC_W    (INC_W),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .inc_en (w_in_count & toggle_trigger & inc_valid[gi]),
      .amount (inc_amount[gi*INC_W +: INC_W]),
      .clear  (w_in_clear),
      .snap   (snapshot_trigger),
      .cnt    (w_live[gi]),
      .shadow (w_shad[gi]),
      .ovf    (ovf_sticky[gi])
    );
  end

  // Indices with no matching lane fall through to zero.
  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) w_rd_sel = rd_shadow ? w_shad[i] : w_live[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_sel;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: three configurations driven in lockstep
// and compared every cycle against an arithmetic reference model.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        toggle_trigger = 1'b0;
  logic        clear_trigger = 1'b0;
  logic        snapshot_trigger = 1'b0;
  logic [3:0]  inc_valid = '0;
  logic [15:0] inc_amount = '0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_idx = '0;
  logic        rd_shadow = 1'b0;

  logic        rdv0, rdv1, rdv2;
  logic [15:0] rdd0;
  logic [7:0]  rdd1, rdd2;
  logic [3:0]  ovf0, ovf1, ovf2;
  logic        cnt0, cnt1, cnt2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CNT(4), .WIDTH(16), .INC_W(4), .SATURATE(0), .IDX_W(3)) u_w16 (
    .clk(clk), .rst(rst), .toggle_trigger(toggle_trigger), .clear_trigger(clear_trigger),
    .snapshot_trigger(snapshot_trigger), .inc_valid(inc_valid), .inc_amount(inc_amount),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_shadow(rd_shadow),
    .rd_valid(rdv0), .rd_data(rdd0), .ovf_sticky(ovf0), .counting(cnt0));

  perf_counter_bank #(.NUM_CNT(4), .WIDTH(8), .INC_W(4), .SATURATE(0), .IDX_W(3)) u_w8 (
    .clk(clk), .rst(rst), .toggle_trigger(toggle_trigger), .clear_trigger(clear_trigger),
    .snapshot_trigger(snapshot_trigger), .inc_valid(inc_valid), .inc_amount(inc_amount),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_shadow(rd_shadow),
    .rd_valid(rdv1), .rd_data(rdd1), .ovf_sticky(ovf1), .counting(cnt1));

  perf_counter_bank #(.NUM_CNT(4), .WIDTH(8), .INC_W(4), .SATURATE(1), .IDX_W(3)) u_s8 (
    .clk(clk), .rst(rst), .toggle_trigger(toggle_trigger), .clear_trigger(clear_trigger),
    .snapshot_trigger(snapshot_trigger), .inc_valid(inc_valid), .inc_amount(inc_amount),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_shadow(rd_shadow),
    .rd_valid(rdv2), .rd_data(rdd2), .ovf_sticky(ovf2), .counting(cnt2));

  // Reference model: index k = 0 (16-bit wrap), 1 (8-bit wrap), 2 (8-bit saturate).
  longint m_cnt [3][4];
  longint m_sh  [3][4];
  bit     m_ovf [3][4];
  longint m_rdd [3];
  bit     m_rdv;
  int     m_mode;  // 0 idle, 1 counting, 2 clearing

  function automatic longint maxv(input int k);
    return (k == 0) ? 64'd65535 : 64'd255;
  endfunction

  function automatic logic [3:0] ovf_vec(input int k);
    logic [3:0] v;
    for (int l = 0; l < 4; l++) v[l] = m_ovf[k][l];
    return v;
  endfunction

  task automatic model_step();
    longint s;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_rdd[k] = 0;
        for (int l = 0; l < 4; l++) begin
          m_cnt[k][l] = 0; m_sh[k][l] = 0; m_ovf[k][l] = 0;
        end
      end
      m_rdv  = 0;
      m_mode = 0;
    end else begin
      m_rdv = rd_en;
      if (rd_en) begin
        for (int k = 0; k < 3; k++) begin
          if (int'(rd_idx) < 4) m_rdd[k] = rd_shadow ? m_sh[k][int'(rd_idx)] : m_cnt[k][int'(rd_idx)];
          else m_rdd[k] = 0;
        end
      end
      if (snapshot_trigger)
        for (int k = 0; k < 3; k++) for (int l = 0; l < 4; l++) m_sh[k][l] = m_cnt[k][l];
      case (m_mode)
        0: begin
          if (clear_trigger) m_mode = 2;
          else if (toggle_trigger) m_mode = 1;
        end
        1: begin
          for (int k = 0; k < 3; k++) begin
            for (int l = 0; l < 4; l++) begin
              if (inc_valid[l] && toggle_trigger) begin
                s = m_cnt[k][l] + longint'(inc_amount[l*4 +: 4]);
                if (s > maxv(k)) begin
                  m_ovf[k][l] = 1;
                  m_cnt[k][l] = (k == 2) ? maxv(k) : s - (maxv(k) + 1);
                end else begin
                  m_cnt[k][l] = s;
                end
              end
            end
          end
          if (clear_trigger) m_mode = 2;
        end
        default: begin
          for (int k = 0; k < 3; k++)
            for (int l = 0; l < 4; l++) begin m_cnt[k][l] = 0; m_ovf[k][l] = 0; end
          m_mode = 0;
        end
      endcase
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check("m_rdv16", 64'(rdv0), 64'(m_rdv));
    check("m_rdv8w", 64'(rdv1), 64'(m_rdv));
    check("m_rdv8s", 64'(rdv2), 64'(m_rdv));
    check("m_rdd16", 64'(rdd0), m_rdd[0]);
    check("m_rdd8w", 64'(rdd1), m_rdd[1]);
    check("m_rdd8s", 64'(rdd2), m_rdd[2]);
    check("m_ovf16", 64'(ovf0), 64'(ovf_vec(0)));
    check("m_ovf8w", 64'(ovf1), 64'(ovf_vec(1)));
    check("m_ovf8s", 64'(ovf2), 64'(ovf_vec(2)));
    check("m_cnt16", 64'(cnt0), 64'(m_mode == 1));
    check("m_cnt8w", 64'(cnt1), 64'(m_mode == 1));
    check("m_cnt8s", 64'(cnt2), 64'(m_mode == 1));
  end

  task automatic tick(); @(negedge clk); endtask

  task automatic set_inc(input int lane, input int amt);
    inc_valid  = 4'(1 << lane);
    inc_amount = 16'(amt) << (lane * 4);
  endtask

  task automatic no_inc();
    inc_valid = '0; inc_amount = '0;
  endtask

  task automatic inc_n(input int lane, input int amt, input int n);
    set_inc(lane, amt);
    repeat (n) tick();
    no_inc();
  endtask

  task automatic rd(input string name, input int idx, input bit sh,
                    input longint e16, input longint e8w, input longint e8s);
    rd_en = 1'b1; rd_idx = 3'(idx); rd_shadow = sh;
    tick();
    rd_en = 1'b0;
    check({name, "_v"}, 64'({rdv0, rdv1, rdv2}), 64'd7);
    check({name, "_16"}, 64'(rdd0), e16);
    check({name, "_8w"}, 64'(rdd1), e8w);
    check({name, "_8s"}, 64'(rdd2), e8s);
  endtask

  initial begin
    tick();
    rst = 1'b0;
    check("rst_counting", 64'({cnt0, cnt1, cnt2}), 64'd0);
    check("rst_rdv", 64'({rdv0, rdv1, rdv2}), 64'd0);
    rd("rst_rd0", 0, 0, 0, 0, 0);

    // basic count: 10 x 3 on lane 0
    toggle_trigger = 1'b1;
    tick();
    inc_n(0, 3, 10);
    rd("basic_l0", 0, 0, 30, 30, 30);
    rd("basic_l1", 1, 0, 0, 0, 0);
    rd("basic_l2", 2, 0, 0, 0, 0);
    rd("basic_l3", 3, 0, 0, 0, 0);

    // pause: toggle low blocks increments, FSM stays counting
    toggle_trigger = 1'b0;
    inc_n(0, 3, 5);
    check("pause_counting", 64'({cnt0, cnt1, cnt2}), 64'd7);
    rd("pause_l0", 0, 0, 30, 30, 30);

    // clear with a same-cycle increment
    toggle_trigger = 1'b1; clear_trigger = 1'b1; set_inc(0, 3);
    tick();
    toggle_trigger = 1'b0; clear_trigger = 1'b0; no_inc();
    rd("clr_pre", 0, 0, 33, 33, 33);
    check("clr_idle", 64'({cnt0, cnt1, cnt2}), 64'd0);
    rd("clr_post", 0, 0, 0, 0, 0);
    check("clr_ovf", 64'({ovf0, ovf1, ovf2}), 64'd0);

    // overflow: 250 + 9
    toggle_trigger = 1'b1;
    tick();
    inc_n(0, 15, 16);
    inc_n(0, 10, 1);
    rd("pre_ovf", 0, 0, 250, 250, 250);
    inc_n(0, 9, 1);
    rd("ovf_l0", 0, 0, 259, 3, 255);
    check("ovf_w16", 64'(ovf0), 64'd0);
    check("ovf_w8", 64'(ovf1), 64'd1);
    check("ovf_s8", 64'(ovf2), 64'd1);
    inc_n(0, 1, 1);
    inc_n(0, 0, 1);
    rd("post_ovf", 0, 0, 260, 4, 255);
    check("ovf_sticky_w8", 64'(ovf1), 64'd1);
    check("ovf_sticky_s8", 64'(ovf2), 64'd1);
    clear_trigger = 1'b1;
    tick();
    clear_trigger = 1'b0;
    tick();
    check("ovf_cleared", 64'({ovf0, ovf1, ovf2}), 64'd0);
    rd("ovf_clr_rd", 0, 0, 0, 0, 0);

    // snapshot-and-clear on lane 2
    tick();
    inc_n(2, 15, 6);
    inc_n(2, 10, 1);
    toggle_trigger = 1'b0;
    snapshot_trigger = 1'b1; clear_trigger = 1'b1;
    tick();
    clear_trigger = 1'b0;
    tick();
    snapshot_trigger = 1'b0;
    rd("snap_sh2", 2, 1, 100, 100, 100);
    rd("snap_lv2", 2, 0, 0, 0, 0);
    rd("oob_live", 7, 0, 0, 0, 0);
    rd("oob_shad", 7, 1, 0, 0, 0);

    // reset mid-run with a pending read
    toggle_trigger = 1'b1;
    tick();
    tick();
    inc_n(3, 15, 18);
    rd("run_l3", 3, 0, 270, 14, 255);
    check("run_ovf8w", 64'(ovf1), 64'd8);
    set_inc(1, 5); rd_en = 1'b1; rd_idx = 3'd3; rst = 1'b1;
    tick();
    rst = 1'b0; rd_en = 1'b0; toggle_trigger = 1'b0; no_inc();
    check("mrst_rdv", 64'({rdv0, rdv1, rdv2}), 64'd0);
    check("mrst_counting", 64'({cnt0, cnt1, cnt2}), 64'd0);
    check("mrst_ovf", 64'({ovf0, ovf1, ovf2}), 64'd0);
    check("mrst_rdd", 64'({rdd0, rdd1, rdd2}), 64'd0);
    rd("mrst_l3", 3, 0, 0, 0, 0);
    rd("mrst_sh2", 2, 1, 0, 0, 0);
    rd("mrst_l1", 1, 0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
